// File: rtl/avalonmm_master.sv
// Avalon-MM burst master: one command at a time, single-word
// reads or writes at incrementing word addresses.
module avalonmm_master #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 5,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [LEN_W-1:0]  cmd_length,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int LAT_W = (READ_LATENCY < 1) ? 1
                       : $clog2(READ_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_SMP = LAT_W'(READ_LATENCY - 1);
  localparam logic [LAT_W-1:0] LAT_END = LAT_W'(READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_BUS,
    S_RD_BUS,
    S_RD_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_count;
  logic [LAT_W-1:0]  r_lat;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_avm_read;
  logic              r_avm_write;
  logic              w_last;
  logic              w_lat_end;
  logic              w_step;

  assign w_last    = (r_count == LEN_W'(1));
  assign w_lat_end = (r_lat == LAT_END);
  assign w_step    = ((r_state == S_WR_BUS) && !avm_waitrequest)
                  || ((r_state == S_RD_WAIT) && w_lat_end);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_length == '0)
            w_next = S_DONE;
          else if (cmd_write)
            w_next = S_WR_DATA;
          else
            w_next = S_RD_BUS;
        end
      end
      S_WR_DATA: begin
        if (wr_valid)
          w_next = S_WR_BUS;
      end
      S_WR_BUS: begin
        if (!avm_waitrequest)
          w_next = w_last ? S_DONE : S_WR_DATA;
      end
      S_RD_BUS: begin
        if (!avm_waitrequest)
          w_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (w_lat_end)
          w_next = w_last ? S_DONE : S_RD_BUS;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Bus strobes and status are registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_count     <= '0;
      r_lat       <= '0;
      r_wdata     <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_avm_read  <= 1'b0;
      r_avm_write <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_DONE);
      r_avm_read  <= (w_next == S_RD_BUS);
      r_avm_write <= (w_next == S_WR_BUS);
      r_rd_valid  <= 1'b0;
      if ((r_state == S_IDLE) && cmd_valid) begin
        r_addr  <= cmd_address;
        r_count <= cmd_length;
      end
      if ((r_state == S_WR_DATA) && wr_valid)
        r_wdata <= wr_data;
      if (w_step) begin
        r_addr  <= r_addr + ADDR_W'(1);
        r_count <= r_count - LEN_W'(1);
      end
      // Extra RD_WAIT cycle after sampling carries the rd_valid pulse
      if (r_state == S_RD_WAIT) begin
        if (!w_lat_end)
          r_lat <= r_lat + LAT_W'(1);
        if (r_lat == LAT_SMP) begin
          r_rd_data  <= avm_readdata;
          r_rd_valid <= 1'b1;
        end
      end else begin
        r_lat <= '0;
      end
    end
  end

  assign cmd_ready     = (r_state == S_IDLE);
  assign wr_ready      = (r_state == S_WR_DATA);
  assign rd_valid      = r_rd_valid;
  assign rd_data       = r_rd_data;
  assign busy          = r_busy;
  assign done          = r_done;
  assign avm_address   = r_addr;
  assign avm_read      = r_avm_read;
  assign avm_write     = r_avm_write;
  assign avm_writedata = r_wdata;

endmodule

// File: tb/tb_avalonmm_master.sv
// Directed bench for avalonmm_master against a latency-1
// register slave model with a controllable waitrequest.
module tb_avalonmm_master;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [3:0]  cmd_address;
  logic [4:0]  cmd_length;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic [3:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  avalonmm_master #(
    .ADDR_W(4), .DATA_W(32), .LEN_W(5), .READ_LATENCY(1)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_address(cmd_address),
    .cmd_length(cmd_length),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .done(done),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (avm_write && !avm_waitrequest)
      mem[avm_address] <= avm_writedata;
    if (avm_read && !avm_waitrequest)
      avm_readdata <= mem[avm_address];
  end

  int          n_vec = 0;
  int          n_bad = 0;
  int          n_wr, n_wr_cyc, n_rd_cyc, n_rv, n_done, n_busy;
  int          n_both = 0;
  int          done_cyc, rv_last, c0, wr_idx;
  logic [3:0]  wa_log [8];
  logic [31:0] wd_log [8];
  logic [31:0] rd_log [8];
  logic [31:0] wq [8];

  always @(negedge clk) begin
    if (avm_write && !avm_waitrequest) begin
      wa_log[n_wr[2:0]] = avm_address;
      wd_log[n_wr[2:0]] = avm_writedata;
      n_wr++;
    end
    if (avm_write) n_wr_cyc++;
    if (avm_read) n_rd_cyc++;
    if (avm_read && avm_write) n_both++;
    if (rd_valid) begin
      rd_log[n_rv[2:0]] = rd_data;
      n_rv++;
      rv_last = cyc;
    end
    if (done) begin
      if (n_done == 0) done_cyc = cyc;
      n_done++;
    end
    if (busy) n_busy++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_wr = 0; n_wr_cyc = 0; n_rd_cyc = 0; n_rv = 0;
    n_done = 0; n_busy = 0; done_cyc = -1; rv_last = -1;
  endtask

  task automatic tick();
    bit hs;
    hs = wr_valid && wr_ready;
    @(posedge clk);
    #1;
    if (hs) wr_idx++;
    wr_data = wq[wr_idx[2:0]];
  endtask

  task automatic load_wq(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] c);
    wq[0] = a; wq[1] = b; wq[2] = c;
    wr_idx = 0;
    wr_data = wq[0];
  endtask

  task automatic send_cmd(input logic w,
                          input logic [3:0] a,
                          input logic [4:0] l);
    cmd_valid = 1'b1; cmd_write = w;
    cmd_address = a; cmd_length = l;
    c0 = cyc;
    chk("cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int k;
    k = 0;
    while (n_done == 0 && k < max) begin
      tick();
      k++;
    end
    chk({tag, "_timeout"}, 32'(n_done != 0), 32'd1);
    tick();
    tick();
  endtask

  initial begin
    int unstable;
    int wr_snap;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) wq[i] = '0;
    avm_readdata = '0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_address = '0; cmd_length = '0;
    wr_valid = 1'b0; wr_data = '0; wr_idx = 0;
    avm_waitrequest = 1'b0;
    clr();
    repeat (3) tick();
    chk("rst_ctl",
        {25'd0, busy, done, avm_read, avm_write,
         rd_valid, wr_ready, cmd_ready}, 32'h01);
    chk("rst_addr", 32'(avm_address), 32'h0);
    chk("rst_wdata", avm_writedata, 32'h0);
    chk("rst_rdata", rd_data, 32'h0);
    reset = 1'b0;
    tick();

    // write burst 0x2, 3 words
    load_wq(32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003);
    wr_valid = 1'b1;
    clr();
    send_cmd(1'b1, 4'h2, 5'd3);
    wait_done("wr3", 30);
    chk("wr3_n", n_wr, 3);
    chk("wr3_a0", 32'(wa_log[0]), 32'h2);
    chk("wr3_a1", 32'(wa_log[1]), 32'h3);
    chk("wr3_a2", 32'(wa_log[2]), 32'h4);
    chk("wr3_d0", wd_log[0], 32'hA5A5_0001);
    chk("wr3_d1", wd_log[1], 32'hA5A5_0002);
    chk("wr3_d2", wd_log[2], 32'hA5A5_0003);
    chk("wr3_wcyc", n_wr_cyc, 3);
    chk("wr3_done_n", n_done, 1);
    chk("wr3_done_at", done_cyc - c0, 7);
    chk("wr3_busy", n_busy, 7);

    // read back 0x2, 3 words
    wr_valid = 1'b0;
    clr();
    send_cmd(1'b0, 4'h2, 5'd3);
    wait_done("rd3", 40);
    chk("rd3_n", n_rv, 3);
    chk("rd3_d0", rd_log[0], 32'hA5A5_0001);
    chk("rd3_d1", rd_log[1], 32'hA5A5_0002);
    chk("rd3_d2", rd_log[2], 32'hA5A5_0003);
    chk("rd3_rcyc", n_rd_cyc, 3);
    chk("rd3_lastrv", rv_last - c0, 9);
    chk("rd3_done_at", done_cyc - c0, 10);
    chk("rd3_busy", n_busy, 10);
    chk("rd3_hold", rd_data, 32'hA5A5_0003);

    // waitrequest 4 cycles on second word
    load_wq(32'h1111_1111, 32'h2222_2222, 32'h0);
    wr_valid = 1'b1;
    clr();
    unstable = 0;
    send_cmd(1'b1, 4'h8, 5'd2);
    repeat (12) begin
      avm_waitrequest = ((cyc - c0) >= 4) && ((cyc - c0) <= 7);
      if ((cyc - c0) >= 4 && (cyc - c0) <= 8)
        if (!(avm_write && avm_address == 4'h9
              && avm_writedata == 32'h2222_2222))
          unstable++;
      tick();
    end
    avm_waitrequest = 1'b0;
    chk("stall_stable", unstable, 0);
    chk("stall_n", n_wr, 2);
    chk("stall_wcyc", n_wr_cyc, 6);
    chk("stall_done_at", done_cyc - c0, 9);
    chk("stall_done_n", n_done, 1);
    chk("stall_mem9", mem[9], 32'h2222_2222);

    // address wrap 0xE..0x0
    load_wq(32'hC0DE_000E, 32'hC0DE_000F, 32'hC0DE_0010);
    clr();
    send_cmd(1'b1, 4'hE, 5'd3);
    wait_done("wrap", 30);
    chk("wrap_a0", 32'(wa_log[0]), 32'hE);
    chk("wrap_a1", 32'(wa_log[1]), 32'hF);
    chk("wrap_a2", 32'(wa_log[2]), 32'h0);
    chk("wrap_d2", wd_log[2], 32'hC0DE_0010);

    // zero-length command
    wr_valid = 1'b0;
    clr();
    send_cmd(1'b0, 4'h5, 5'd0);
    wait_done("len0", 10);
    chk("len0_done_at", done_cyc - c0, 1);
    chk("len0_busy", n_busy, 1);
    chk("len0_bus", n_rd_cyc + n_wr_cyc, 0);

    // reset during RD_WAIT of word 2 of 4
    clr();
    send_cmd(1'b0, 4'h2, 5'd4);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_ctl", {30'd0, avm_read, busy}, 32'h0);
    chk("abort_rv", 32'(rd_valid), 32'h0);
    repeat (6) tick();
    chk("abort_nrv", n_rv, 1);
    chk("abort_d0", rd_log[0], 32'hA5A5_0001);
    chk("abort_done", n_done, 0);
    clr();
    send_cmd(1'b0, 4'h3, 5'd1);
    wait_done("post", 20);
    chk("post_nrv", n_rv, 1);
    chk("post_d", rd_log[0], 32'hA5A5_0002);
    chk("post_done_at", done_cyc - c0, 4);

    // wr_valid withheld 5 cycles
    load_wq(32'h7777_0007, 32'h0, 32'h0);
    wr_valid = 1'b0;
    clr();
    send_cmd(1'b1, 4'h7, 5'd1);
    repeat (5) tick();
    wr_snap = n_wr_cyc;
    chk("hold_wready", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1;
    wait_done("hold", 20);
    chk("hold_wcyc0", wr_snap, 0);
    chk("hold_n", n_wr, 1);
    chk("hold_a", 32'(wa_log[0]), 32'h7);
    chk("hold_d", wd_log[0], 32'h7777_0007);
    chk("hold_done_at", done_cyc - c0, 8);

    chk("rw_exclusive", n_both, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/avalonmm_master.md
# avalonmm_master

Command-driven Avalon-MM master issuing bursts of single-word reads or writes at incrementing word addresses. It is the initiator counterpart of the team's Avalon-MM register slaves, which use 4-bit word addresses, 32-bit data and a fixed registered read latency. A local controller loads one command at a time. Write data is pulled through a valid/ready stream, and read data is returned as a one-cycle-valid stream.

## Interface
- ADDR_W, 4: Avalon word-address width.
- DATA_W, 32: data width.
- LEN_W, 5: command length width, in words.
- READ_LATENCY, 1: fixed cycles from read acceptance to slave readdata valid (≥1).

- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_address  in  ADDR_W  first word address.
- cmd_length  in  LEN_W  number of words (0 allowed).
- wr_valid  in  1  write word offered.
- wr_ready  out  1  high only in WR_DATA.
- wr_data  in  DATA_W  write word.
- rd_valid  out  1  one-cycle pulse per returned word.
- rd_data  out  DATA_W  returned word; held until the next rd_valid.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- avm_address  out  ADDR_W  bus address.
- avm_read  out  1  bus read request.
- avm_write  out  1  bus write request.
- avm_writedata  out  DATA_W  bus write data.
- avm_readdata  in  DATA_W  bus read data.
- avm_waitrequest  in  1  slave stall; tie 0 for slaves with no stall.

## Operation
- States: IDLE, WR_DATA, WR_BUS, RD_BUS, RD_WAIT, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch address, length and direction into internal registers; busy rises next cycle.
  - length==0 → DONE; no bus access.
  - Otherwise write → WR_DATA, read → RD_BUS.
- WR_DATA:
  - wr_ready=1.
  - On wr_valid, register wr_data into avm_writedata → WR_BUS.
- WR_BUS:
  - avm_write=1; address and writedata held stable.
  - Transfer completes in the first cycle with avm_waitrequest=0.
  - On completion: address+1, count−1; count reaches 0 → DONE, else → WR_DATA.
- RD_BUS:
  - avm_read=1, held until a cycle with avm_waitrequest=0 (acceptance) → RD_WAIT.
- RD_WAIT:
  - Latency counter runs READ_LATENCY cycles.
  - avm_readdata is sampled at the end of the last cycle into rd_data; rd_valid=1 in the following cycle.
  - address+1, count−1; count reaches 0 → DONE, else → RD_BUS.
- DONE:
  - done=1 for one cycle → IDLE.
- busy=1 in every state except IDLE.
- Address arithmetic is modulo 2^ADDR_W: address 0xF + 1 wraps to 0x0, with no error.
- avm_read and avm_write are never high together.
- The bus is never driven in IDLE or DONE.
- rd_valid has no backpressure; the consumer must accept every pulse.

## Timing
- Reset values:
  - State = IDLE.
  - avm_read, avm_write, rd_valid, done, busy = 0.
  - avm_address, avm_writedata, rd_data = 0.
  - cmd_ready=1 and wr_ready=0 from the first cycle after reset is sampled.
- Reset asserted mid-command:
  - Aborts at that edge; avm_read and avm_write low the next cycle.
  - No done pulse and no rd_valid pulse; the pending word is dropped.
- All outputs are registered, except cmd_ready and wr_ready, which decode from state.
- Write, zero wait: cmd accept at cycle 0; WR_DATA cycle 1; avm_write high cycle 2; 2 cycles per word minimum.
  - Each waitrequest cycle adds one cycle.
  - wr_valid low in WR_DATA adds one cycle per low cycle.
- Read, zero wait, READ_LATENCY=1:
  - avm_read high cycle 1; sample at end of cycle 2; rd_valid cycle 3.
  - 1+READ_LATENCY+1 cycles per word.
- done pulses in the cycle after the last word's write completion or rd_valid.
- Length-0 command: done in cycle 1, busy high in cycle 1 only.
- cmd_valid is ignored while busy; cmd_ready=0 outside IDLE.

## Test plan
- Write burst cmd(write=1, addr=0x2, len=3), words 0xA5A5_0001/2/3, waitrequest=0 → avm_write pulses at addresses 0x2, 0x3, 0x4 with matching data, one done pulse, busy high for 7 cycles.
- Read back cmd(write=0, addr=0x2, len=3) against the register slave model (latency 1) → rd_valid three times with 0xA5A5_0001/2/3, avm_read high exactly one cycle per word, done after the third rd_valid.
- waitrequest held high 4 cycles on the second word of a 2-word write → avm_write, avm_address and avm_writedata stable through the stall, exactly 2 slave writes, completion delayed by 4 cycles.
- Wrap: cmd(write=1, addr=0xE, len=3) → writes to 0xE, 0xF, 0x0; then cmd(len=0) → done the next cycle, no avm_read or avm_write activity.
- Reset asserted during RD_WAIT of word 2 of 4 → avm_read low, busy 0, no done and no further rd_valid; a new cmd(len=1) is accepted immediately and completes normally.
- wr_valid withheld 5 cycles in WR_DATA → avm_write stays low throughout; the transfer proceeds on the first wr_valid.
